mem_bus_arbiter: RTL and testbench
==================================

# mem_bus_arbiter

Arbitrates the single-outstanding shared memory bus between the instruction-fetch port (IF stage) and the data port (MEM stage) of the five-stage core. It generates `stallreq_from_if` and `stallreq_from_mem` for the hazard unit. It buffers returned read data until the pipeline advances. It discards fetches made stale by a pipeline flush. It sits between the datapath top level and the bus bridge / cache interface.

## Interface
- `DATA_FIRST`, default 1: 1 = data port wins simultaneous requests; 0 = instruction port wins.
---
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `inst_req` in 1: IF requests a fetch at `inst_addr`.
- `inst_addr` in 32: fetch address (word-aligned).
- `inst_rdata` out 32: buffered fetched word.
- `stallreq_from_if` out 1: fetch not yet complete.
- `data_req` in 1: MEM-stage access (mem_en).
- `data_wr` in 1: 1 = store (mem_we).
- `data_size` in 2: 0 = byte, 1 = half, 2 = word.
- `data_addr` in 32: data address.
- `data_wdata` in 32: store data, lane-aligned.
- `data_wstrb` in 4: byte enables (sel).
- `data_rdata` out 32: buffered load word, raw lanes.
- `stallreq_from_mem` out 1: data access not yet complete.
- `pipe_stall` in 1: OR of all stage stalls, including both stallreqs. The pipeline advances only when this is low.
- `flush` in 1: exception flush (wb_flush).
- `bus_req`, `bus_wr` out 1 each.
- `bus_size` out 2.
- `bus_addr`, `bus_wdata` out 32 each.
- `bus_wstrb` out 4.
- `bus_addr_ok`, `bus_data_ok` in 1 each.
- `bus_rdata` in 32.

## Operation
- States: IDLE, DADDR, DDATA, IADDR, IDATA.
- Pending conditions:
  - `d_pend = data_req & ~d_done`
  - `i_pend = inst_req & ~i_done & ~i_discard`
- IDLE:
  - If both are pending, `DATA_FIRST` selects the winner. Otherwise the pending one goes to DADDR or IADDR.
  - On the transition edge, the request fields are latched into internal registers. Bus outputs are driven only from these registers.
  - Inst requests are latched with `wr=0`, `size=2`, `wstrb=4'b0000`.
- xADDR: `bus_req=1`. On `bus_addr_ok`, go to xDATA; `bus_req` is 0 from the next cycle. `bus_req` is never withdrawn before `bus_addr_ok`.
- xDATA: `bus_req=0`. On `bus_data_ok`, go to IDLE. Also:
  - DDATA: set `d_done`. If it was a read, load `data_rdata <= bus_rdata`.
  - IDATA: if `i_discard`, clear it and leave `inst_rdata`/`i_done` unchanged. Otherwise set `i_done` and load `inst_rdata <= bus_rdata`.
- `bus_data_ok` and `bus_addr_ok` are ignored in IDLE and in the wrong phase.
- Done flags: at each edge with `pipe_stall=0`, clear `i_done` and `d_done`. This has priority over setting.
- Outputs:
  - `stallreq_from_if = inst_req & ~i_done`
  - `stallreq_from_mem = data_req & ~d_done`
- Flush:
  - At an edge with `flush=1`, clear `i_done`.
  - If the state is IADDR or IDATA, set `i_discard`. The outstanding fetch completes on the bus and is dropped.
  - `i_discard` blocks new inst arbitration until it is cleared.
  - Data accesses are never discarded: the MEM stage gates faulting accesses before requesting.
- Writes: `data_rdata` holds its previous value.

## Timing
- Reset values:
  - state IDLE.
  - `bus_req`, `bus_wr`, `bus_size`, `bus_addr`, `bus_wdata`, `bus_wstrb` all 0.
  - `inst_rdata` and `data_rdata` 0.
  - `i_done`, `d_done`, `i_discard` 0.
- Reset mid-transaction: return to IDLE immediately. Late `bus_data_ok` is ignored.
- Best-case latency, zero-wait bus (`addr_ok` in the first xADDR cycle, `data_ok` the cycle after):
  - Request seen in IDLE at cycle 0.
  - `bus_req` high in cycle 1.
  - `data_ok` in cycle 2.
  - Stallreq low in cycle 3, with data valid in cycle 3.
- After every transaction there is one IDLE cycle before the next request.
- Both requesters pending: serve the winner first, then the loser. The loser's stallreq stays high throughout.
- The stallreq of a completed port stays low while `pipe_stall` remains high, and its buffered data stays stable.

## Test plan
- Single fetch, zero-wait bus: `inst_req=1`, `inst_addr=0xBFC00000`, `bus_rdata=0x3C010001`.
  - Expect `bus_req` in cycle 1 with `bus_addr=0xBFC00000`, `bus_wr=0`, `bus_size=2`, `bus_wstrb=4'b0000`.
  - Expect `stallreq_from_if` to fall in cycle 3 with `inst_rdata=0x3C010001`.
- Collision, `DATA_FIRST=1`: in the same cycle, fetch at 0x100 and store at 0x200 with `wdata=0xDEADBEEF`, `wstrb=4'b1111`.
  - Expect the store to issue first, then the fetch.
  - `stallreq_from_mem` falls about 3 cycles before `stallreq_from_if`.
- Hold under external stall: fetch completes while `pipe_stall` is held high 5 extra cycles.
  - `inst_rdata` stays stable, no new bus request occurs, `stallreq_from_if=0`.
  - `i_done` clears on the first edge with `pipe_stall=0`.
- Flush during IDATA, with `data_ok` delayed 4 cycles: assert `flush` for one cycle.
  - The returned word is dropped and `inst_rdata` keeps its old value.
  - A new fetch of the new `inst_addr` issues in the first IDLE after the drop.
- Slow `addr_ok`: hold `bus_addr_ok=0` for 6 cycles on a byte load at 0x203.
  - `bus_req`, `bus_addr=0x203`, `bus_size=0` stay constant throughout.
  - Changes to the `data_*` inputs during this period do not affect the bus.
- Reset asserted in DDATA: outputs go to their reset values asynchronously. A later `bus_data_ok` leaves `data_rdata=0`.

Source files
------------

// File: rtl/mem_bus_arbiter_if.sv
// mem_bus_arbiter_if: core-side request ports and shared memory bus signals of the arbiter.
interface mem_bus_arbiter_if;
    logic        inst_req;
    logic [31:0] inst_addr;
    logic [31:0] inst_rdata;
    logic        stallreq_from_if;
    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [31:0] data_wdata;
    logic [3:0]  data_wstrb;
    logic [31:0] data_rdata;
    logic        stallreq_from_mem;
    logic        pipe_stall;
    logic        flush;
    logic        bus_req;
    logic        bus_wr;
    logic [1:0]  bus_size;
    logic [31:0] bus_addr;
    logic [31:0] bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_addr_ok;
    logic        bus_data_ok;
    logic [31:0] bus_rdata;

    modport master (
        input  inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        input  pipe_stall, flush, bus_addr_ok, bus_data_ok, bus_rdata,
        output inst_rdata, stallreq_from_if, data_rdata, stallreq_from_mem,
        output bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
    );

    modport slave (
        output inst_req, inst_addr, data_req, data_wr, data_size, data_addr, data_wdata, data_wstrb,
        output pipe_stall, flush, bus_addr_ok, bus_data_ok, bus_rdata,
        input  inst_rdata, stallreq_from_if, data_rdata, stallreq_from_mem,
        input  bus_req, bus_wr, bus_size, bus_addr, bus_wdata, bus_wstrb
    );
endinterface

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter: shares one single-outstanding memory bus between the fetch and data ports,
// buffering returned words until the pipeline advances and dropping fetches killed by a flush.
module mem_bus_arbiter #(
    parameter bit DATA_FIRST = 1'b1
) (
    input logic clk,
    input logic rst,
    mem_bus_arbiter_if.master mb
);
    typedef enum logic [2:0] {IDLE, DADDR, DDATA, IADDR, IDATA} state_t;

    state_t      state, next;
    logic        i_done, d_done, i_discard;
    logic        i_pend, d_pend, i_fin, d_fin, fetching;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, inst_q, data_q;
    logic [3:0]  wstrb_q;

    assign d_pend   = mb.data_req & ~d_done;
    assign i_pend   = mb.inst_req & ~i_done & ~i_discard;
    assign d_fin    = state == DDATA && mb.bus_data_ok;
    assign i_fin    = state == IDATA && mb.bus_data_ok;
    assign fetching = state == IADDR || state == IDATA;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = (d_pend && (DATA_FIRST || !i_pend)) ? DADDR : i_pend ? IADDR : IDLE;
            DADDR:   next = mb.bus_addr_ok ? DDATA : DADDR;
            DDATA:   next = mb.bus_data_ok ? IDLE : DDATA;
            IADDR:   next = mb.bus_addr_ok ? IDATA : IADDR;
            IDATA:   next = mb.bus_data_ok ? IDLE : IDATA;
            default: next = IDLE;
        endcase
    end

    // A flush landing on the completing edge drops that word directly instead of arming i_discard.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            wr_q      <= 1'b0;
            size_q    <= 2'd0;
            addr_q    <= '0;
            wdata_q   <= '0;
            wstrb_q   <= '0;
            inst_q    <= '0;
            data_q    <= '0;
            i_done    <= 1'b0;
            d_done    <= 1'b0;
            i_discard <= 1'b0;
        end else begin
            state <= next;
            if (state == IDLE && next == DADDR) begin
                wr_q    <= mb.data_wr;
                size_q  <= mb.data_size;
                addr_q  <= mb.data_addr;
                wdata_q <= mb.data_wdata;
                wstrb_q <= mb.data_wstrb;
            end else if (state == IDLE && next == IADDR) begin
                wr_q    <= 1'b0;
                size_q  <= 2'd2;
                addr_q  <= mb.inst_addr;
                wdata_q <= '0;
                wstrb_q <= '0;
            end
            if (d_fin && !wr_q) data_q <= mb.bus_rdata;
            if (i_fin && !i_discard && !mb.flush) inst_q <= mb.bus_rdata;
            d_done    <= mb.pipe_stall & (d_done | d_fin);
            i_done    <= mb.pipe_stall & ~mb.flush & (i_done | (i_fin & ~i_discard));
            i_discard <= i_fin ? 1'b0 : (i_discard | (mb.flush & fetching));
        end
    end

    assign mb.bus_req           = state == DADDR || state == IADDR;
    assign mb.bus_wr            = wr_q;
    assign mb.bus_size          = size_q;
    assign mb.bus_addr          = addr_q;
    assign mb.bus_wdata         = wdata_q;
    assign mb.bus_wstrb         = wstrb_q;
    assign mb.inst_rdata        = inst_q;
    assign mb.data_rdata        = data_q;
    assign mb.stallreq_from_if  = mb.inst_req & ~i_done;
    assign mb.stallreq_from_mem = mb.data_req & ~d_done;
endmodule

// File: tb/tb_mem_bus_arbiter.sv
// tb_mem_bus_arbiter: vector table plus hand-written corner sequences; a bus responder pops the
// expected-transaction queue at each address handshake.
module tb_mem_bus_arbiter;
    typedef struct {
        bit          is_data;
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          aw;
        int          dw;
    } vec_t;

    typedef struct {
        bit          wr;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        bit          inst;
    } bus_t;

    logic clk = 1'b0;
    logic rst;
    logic ext_stall;
    int   passed = 0;
    int   total = 0;
    int   addr_wait = 0;
    int   data_wait = 0;
    bit   manual = 1'b0;
    bit   man_aok = 1'b0;
    bit   man_dok = 1'b0;
    logic [31:0] man_rdata = '0;
    logic [31:0] exp_ird = '0;
    logic [31:0] exp_drd = '0;
    bus_t        exp_q[$];
    logic [31:0] rd_q[$];
    vec_t        vecs[7];

    always #5 clk = ~clk;

    mem_bus_arbiter_if mb();
    assign mb.pipe_stall = mb.stallreq_from_if | mb.stallreq_from_mem | ext_stall;

    mem_bus_arbiter #(.DATA_FIRST(1'b1)) dut (.clk(clk), .rst(rst), .mb(mb));

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    task automatic issue(input vec_t v);
        if (v.is_data) begin
            mb.data_req = 1'b1;
            mb.data_wr = v.wr;
            mb.data_size = v.size;
            mb.data_addr = v.addr;
            mb.data_wdata = v.wdata;
            mb.data_wstrb = v.wstrb;
            exp_q.push_back('{v.wr, v.size, v.addr, v.wdata, v.wstrb, 1'b0});
        end else begin
            mb.inst_req = 1'b1;
            mb.inst_addr = v.addr;
            exp_q.push_back('{1'b0, 2'd2, v.addr, 32'h0, 4'h0, 1'b1});
        end
        rd_q.push_back(v.rdata);
    endtask

    task automatic wait_done(input bit is_data, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((is_data ? mb.stallreq_from_mem : mb.stallreq_from_if) && n < 200);
        if (n >= 200) check("wait_timeout", 32'(n), 32'(0));
    endtask

    // Bus responder: answers just after each falling edge, addr_ok after addr_wait cycles of bus_req.
    initial begin
        int   acnt;
        int   dcnt;
        bit   in_data;
        bus_t e;
        acnt = 0;
        dcnt = 0;
        in_data = 1'b0;
        mb.bus_addr_ok = 1'b0;
        mb.bus_data_ok = 1'b0;
        mb.bus_rdata = '0;
        forever begin
            @(negedge clk);
            #1;
            if (manual) begin
                mb.bus_addr_ok = man_aok;
                mb.bus_data_ok = man_dok;
                mb.bus_rdata = man_rdata;
                in_data = 1'b0;
                acnt = 0;
                dcnt = 0;
            end else begin
                mb.bus_addr_ok = 1'b0;
                mb.bus_data_ok = 1'b0;
                if (in_data) begin
                    if (dcnt >= data_wait) begin
                        mb.bus_data_ok = 1'b1;
                        mb.bus_rdata = rd_q.size() > 0 ? rd_q.pop_front() : 32'h0;
                        in_data = 1'b0;
                        dcnt = 0;
                    end else dcnt++;
                end else if (mb.bus_req) begin
                    if (acnt >= addr_wait) begin
                        mb.bus_addr_ok = 1'b1;
                        in_data = 1'b1;
                        acnt = 0;
                        if (exp_q.size() == 0) begin
                            total++;
                            $display("FAIL bus_issue: unexpected request at %h", mb.bus_addr);
                        end else begin
                            e = exp_q.pop_front();
                            check("bus_addr", mb.bus_addr, e.addr);
                            check("bus_wr", 32'(mb.bus_wr), 32'(e.wr));
                            check("bus_size", 32'(mb.bus_size), 32'(e.size));
                            check("bus_wstrb", 32'(mb.bus_wstrb), 32'(e.wstrb));
                            if (!e.inst) check("bus_wdata", mb.bus_wdata, e.wdata);
                        end
                    end else acnt++;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int tm;
        int ti;
        int bad;
        vecs[0] = '{1'b0, 1'b0, 2'd2, 32'hBFC00000, 32'h0, 4'h0, 32'h3C010001, 0, 0};
        vecs[1] = '{1'b1, 1'b0, 2'd2, 32'h00001000, 32'h0, 4'hF, 32'h12345678, 0, 0};
        vecs[2] = '{1'b1, 1'b1, 2'd0, 32'h00002001, 32'h0000AB00, 4'h2, 32'h0, 1, 1};
        vecs[3] = '{1'b1, 1'b0, 2'd1, 32'h00003002, 32'h0, 4'hC, 32'hCAFEF00D, 2, 3};
        vecs[4] = '{1'b0, 1'b0, 2'd2, 32'h00000100, 32'h0, 4'h0, 32'h24020005, 1, 1};
        vecs[5] = '{1'b1, 1'b1, 2'd2, 32'h00004000, 32'hDEADBEEF, 4'hF, 32'h0, 0, 2};
        vecs[6] = '{1'b0, 1'b0, 2'd2, 32'h00000104, 32'h0, 4'h0, 32'h8FA40010, 3, 0};

        rst = 1'b1;
        ext_stall = 1'b0;
        mb.flush = 1'b0;
        mb.inst_req = 1'b0;
        mb.inst_addr = '0;
        mb.data_req = 1'b0;
        mb.data_wr = 1'b0;
        mb.data_size = '0;
        mb.data_addr = '0;
        mb.data_wdata = '0;
        mb.data_wstrb = '0;
        repeat (2) @(negedge clk);
        check("rst_bus_req", 32'(mb.bus_req), 32'(0));
        check("rst_bus_addr", mb.bus_addr, 32'h0);
        check("rst_bus_wr_size_strb", {25'h0, mb.bus_wr, mb.bus_size, mb.bus_wstrb}, 32'h0);
        check("rst_bus_wdata", mb.bus_wdata, 32'h0);
        check("rst_inst_rdata", mb.inst_rdata, 32'h0);
        check("rst_data_rdata", mb.data_rdata, 32'h0);
        check("rst_stallreqs", {30'h0, mb.stallreq_from_if, mb.stallreq_from_mem}, 32'h0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            addr_wait = vecs[i].aw;
            data_wait = vecs[i].dw;
            issue(vecs[i]);
            wait_done(vecs[i].is_data, n);
            check($sformatf("latency_v%0d", i), 32'(n), 32'(3 + vecs[i].aw + vecs[i].dw));
            if (vecs[i].is_data) begin
                if (!vecs[i].wr) exp_drd = vecs[i].rdata;
                check($sformatf("data_rdata_v%0d", i), mb.data_rdata, exp_drd);
            end else begin
                exp_ird = vecs[i].rdata;
                check($sformatf("inst_rdata_v%0d", i), mb.inst_rdata, exp_ird);
            end
            mb.inst_req = 1'b0;
            mb.data_req = 1'b0;
            @(negedge clk);
        end

        // Collision: store wins, fetch waits with its stallreq held high.
        addr_wait = 0;
        data_wait = 0;
        issue('{1'b1, 1'b1, 2'd2, 32'h200, 32'hDEADBEEF, 4'hF, 32'h0, 0, 0});
        issue('{1'b0, 1'b0, 2'd2, 32'h100, 32'h0, 4'h0, 32'h8C220000, 0, 0});
        tm = 0;
        ti = 0;
        for (int c = 1; c <= 60 && ti == 0; c++) begin
            @(negedge clk);
            if (!mb.stallreq_from_mem && tm == 0) begin
                tm = c;
                check("collide_loser_held", 32'(mb.stallreq_from_if), 32'(1));
            end
            if (!mb.stallreq_from_if && ti == 0) begin
                ti = c;
                check("collide_mem_stays_done", 32'(mb.stallreq_from_mem), 32'(0));
            end
        end
        check("collide_mem_cycle", 32'(tm), 32'(3));
        check("collide_if_cycle", 32'(ti), 32'(6));
        exp_ird = 32'h8C220000;
        check("collide_inst_rdata", mb.inst_rdata, exp_ird);
        check("collide_data_rdata", mb.data_rdata, exp_drd);
        mb.inst_req = 1'b0;
        mb.data_req = 1'b0;
        @(negedge clk);

        // Completed fetch held under an external stall.
        ext_stall = 1'b1;
        issue('{1'b0, 1'b0, 2'd2, 32'h200, 32'h0, 4'h0, 32'h5555AAAA, 0, 0});
        wait_done(1'b0, n);
        check("hold_latency", 32'(n), 32'(3));
        exp_ird = 32'h5555AAAA;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("hold_stallreq_if", 32'(mb.stallreq_from_if), 32'(0));
            check("hold_bus_req", 32'(mb.bus_req), 32'(0));
            check("hold_inst_rdata", mb.inst_rdata, exp_ird);
        end
        ext_stall = 1'b0;
        @(negedge clk);
        check("hold_done_cleared", 32'(mb.stallreq_from_if), 32'(1));
        mb.inst_req = 1'b0;
        @(negedge clk);
        check("hold_no_refetch", 32'(mb.bus_req), 32'(0));

        // Flush while the fetch waits in the data phase: word dropped, new address refetched.
        addr_wait = 0;
        data_wait = 4;
        issue('{1'b0, 1'b0, 2'd2, 32'h300, 32'h0, 4'h0, 32'h11111111, 0, 0});
        repeat (2) @(negedge clk);
        mb.flush = 1'b1;
        mb.inst_addr = 32'h400;
        exp_q.push_back('{1'b0, 2'd2, 32'h400, 32'h0, 4'h0, 1'b1});
        rd_q.push_back(32'h22222222);
        n = 0;
        do begin
            @(negedge clk);
            mb.flush = 1'b0;
            n++;
            if (n == 5) begin
                data_wait = 0;
                check("flush_keeps_old", mb.inst_rdata, exp_ird);
                check("flush_not_done", 32'(mb.stallreq_from_if), 32'(1));
            end
            if (n == 6) check("flush_refetch_first_idle", 32'(mb.bus_req), 32'(1));
        end while (mb.stallreq_from_if && n < 60);
        check("flush_total_cycles", 32'(n), 32'(8));
        exp_ird = 32'h22222222;
        check("flush_new_word", mb.inst_rdata, exp_ird);
        mb.inst_req = 1'b0;
        @(negedge clk);

        // Slow addr_ok on a byte load; input changes while waiting must not reach the bus.
        addr_wait = 6;
        issue('{1'b1, 1'b0, 2'd0, 32'h203, 32'h0, 4'h8, 32'h44332211, 6, 0});
        bad = 0;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (c == 0) begin
                mb.data_wr = 1'b1;
                mb.data_size = 2'd2;
                mb.data_addr = 32'hFFFF0000;
                mb.data_wdata = 32'h12345678;
                mb.data_wstrb = 4'hF;
            end
            if (mb.bus_req !== 1'b1 || mb.bus_addr !== 32'h203 || mb.bus_size !== 2'd0 || mb.bus_wr !== 1'b0) bad++;
        end
        check("slow_addr_hold", 32'(bad), 32'(0));
        wait_done(1'b1, n);
        check("slow_addr_latency", 32'(6 + n), 32'(9));
        exp_drd = 32'h44332211;
        check("slow_addr_rdata", mb.data_rdata, exp_drd);
        mb.data_req = 1'b0;
        addr_wait = 0;
        @(negedge clk);

        // Reset while a load sits in the data phase; the late data_ok is ignored.
        manual = 1'b1;
        issue('{1'b1, 1'b0, 2'd2, 32'h500, 32'h0, 4'hF, 32'h0, 0, 0});
        void'(exp_q.pop_back());
        void'(rd_q.pop_back());
        @(negedge clk);
        man_aok = 1'b1;
        @(negedge clk);
        man_aok = 1'b0;
        check("rst_mid_in_ddata", {31'h0, mb.bus_req}, 32'h0);
        check("rst_mid_addr_latched", mb.bus_addr, 32'h500);
        #2 rst = 1'b1;
        #1;
        check("rst_async_bus_addr", mb.bus_addr, 32'h0);
        check("rst_async_bus_wstrb", 32'(mb.bus_wstrb), 32'(0));
        check("rst_async_data_rdata", mb.data_rdata, 32'h0);
        check("rst_async_inst_rdata", mb.inst_rdata, 32'h0);
        mb.data_req = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        man_dok = 1'b1;
        man_rdata = 32'hFFFFFFFF;
        @(negedge clk);
        man_dok = 1'b0;
        @(negedge clk);
        check("rst_late_data_ok", mb.data_rdata, 32'h0);
        check("rst_late_bus_req", 32'(mb.bus_req), 32'(0));
        check("scoreboard_empty", 32'(exp_q.size()), 32'(0));

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
